fpga_test_step_mul_arb: RTL and testbench
=========================================

FPGA_TEST_STEP_MUL_ARB -- requirements
Module: fpga_test_step_mul_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requester ports (2..8).
REQ-002 SHALL have parameter A_W, default 32, meaning the signed multiplicand width.
REQ-003 SHALL have parameter B_W, default 8, meaning the unsigned multiplier width.
REQ-004 SHALL have port ap_clk, input, 1 bit, the single clock; every flop is on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-006 SHALL have port req_valid, input, N_REQ bits: request i is pending.
REQ-007 SHALL have port req_ready, output, N_REQ bits: request i is accepted this cycle.
REQ-008 SHALL have port req_a, input, N_REQ*A_W bits: packed signed operands, slice i = [i*A_W +: A_W].
REQ-009 SHALL have port req_b, input, N_REQ*B_W bits: packed unsigned operands, slice i = [i*B_W +: B_W].
REQ-010 SHALL have port rsp_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port rsp_id, output, clog2(N_REQ) bits: index of the requester that owns rsp_data.
REQ-013 SHALL have port rsp_data, output, A_W bits: the product.
REQ-014 SHALL have port ops_cnt, output, 16 bits: count of completed responses.

Function
REQ-015 SHALL sequence one shared multiplier through FSM states IDLE, MUL and RSP, with one operation outstanding at a time.
REQ-016 In IDLE with any req_valid bit set, SHALL raise req_ready for exactly one requester, combinationally, in the same cycle.
REQ-017 SHALL choose that requester as the first set req_valid bit found searching upward (with wrap) from rr_ptr, then go to MUL.
REQ-018 On a grant to requester g, SHALL register req_a[g], req_b[g] and g, and SHALL set rr_ptr to (g+1) mod N_REQ.
REQ-019 SHALL hold req_ready at 0 in MUL and RSP, and in IDLE when no req_valid bit is set.
REQ-020 In MUL, SHALL compute the product as signed(a) times zero-extended b.
REQ-021 SHALL register the low A_W bits of the product (two's-complement wrap, no saturation) into rsp_data, then go to RSP.
REQ-022 In RSP, SHALL drive rsp_valid=1 and hold rsp_data and rsp_id stable until rsp_ready=1.
REQ-023 On rsp_ready=1 in RSP, SHALL go to IDLE and increment ops_cnt, wrapping from 0xFFFF to 0.
REQ-024 Latency: a request accepted at cycle T SHALL appear as rsp_valid=1 at T+2.
REQ-025 Throughput SHALL be at most one response every 3 cycles.
REQ-026 A requester that lowers req_valid before being granted SHALL simply not be served; there is no error.
REQ-027 SHALL not change rr_ptr outside a grant.
REQ-028 The round-robin scheme SHALL guarantee that a continuously asserted request is granted within N_REQ grants.
REQ-029 rsp_valid SHALL be 0 in IDLE and MUL.

Reset
REQ-030 While ap_rst_n=0 at a clock edge, SHALL set state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0 and ops_cnt=0.
REQ-031 SHALL drive req_ready=0 during reset.
REQ-032 Reset asserted in MUL or RSP SHALL abandon the operation with no response, so the first cycle after reset is IDLE.

Structure
REQ-033 A shared package SHALL hold the state encoding typedef (IDLE, MUL, RSP) and the constants N_REQ, A_W and B_W defaults.
REQ-034 SHALL instantiate the existing combinational core fpga_test_step_mul_32s_8ns_32_1_1 (NUM_STAGE=0) as the single sub-module for the product.
REQ-035 Arbitration and the FSM SHALL be local to this module.

Verification
REQ-036 Single request: req_valid=0001, a=-3, b=200 -> req_ready=0001 in that cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=0xFFFFFDA8; ops_cnt=1 after rsp_ready.
REQ-037 Wrap: a=0x7FFFFFFF, b=2 -> rsp_data=0xFFFFFFFE; a=0x80000000, b=255 -> rsp_data=0x80000000.
REQ-038 Fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, responses 3 cycles apart.
REQ-039 Back-pressure: rsp_ready=0 for 5 cycles in RSP -> rsp_data/rsp_id stable, req_ready=0; the new grant occurs only in the IDLE cycle after rsp_ready=1.
REQ-040 Reset in MUL: ap_rst_n=0 for 1 cycle -> no rsp_valid, ops_cnt=0, rr_ptr=0; the next request on port 2 is granted in IDLE.
REQ-041 Counter wrap: force 65536 completions -> ops_cnt reads 0.

Source files
------------

// File: rtl/fpga_test_step_mul_arb_pkg.sv
// Shared definitions for the round-robin multiplier arbiter: FSM state
// encoding, default geometry and small index helpers.
package fpga_test_step_mul_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_A_W   = 32;
  localparam int DEF_B_W   = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  // Index arithmetic modulo n, used for the round-robin search and pointer.
  function automatic int wrapAdd(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

  function automatic int wrapInc(input int idx, input int n);
    return wrapAdd(idx, 1, n);
  endfunction

endpackage

// File: rtl/fpga_test_step_mul_32s_8ns_32_1_1.sv
// Combinational signed-by-unsigned multiplier core. The product is formed at
// the output width, which yields exactly the low dout_WIDTH bits of the full
// product (two's-complement wrap).
module fpga_test_step_mul_32s_8ns_32_1_1 #(
  parameter int NUM_STAGE  = 0,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 32
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] aExt;
  logic signed [dout_WIDTH-1:0] bExt;
  logic signed [dout_WIDTH-1:0] prod;

  // din0 is sign-extended, din1 is zero-extended before the multiply.
  always_comb begin
    aExt = dout_WIDTH'($signed(din0));
    bExt = dout_WIDTH'({1'b0, din1});
    prod = aExt * bExt;
  end

  // This variant has no pipeline ports, so only the combinational form exists;
  // any other stage count drives zero so a misconfiguration is obvious.
  if (NUM_STAGE == 0) begin : gComb
    assign dout = prod;
  end else begin : gUnsupported
    assign dout = '0;
  end

endmodule

// File: rtl/fpga_test_step_mul_arb.sv
// Round-robin arbiter in front of one shared multiplier. One operation is in
// flight at a time: IDLE grants a requester, MUL registers the product, RSP
// presents it until the consumer takes it.
module fpga_test_step_mul_arb
  import fpga_test_step_mul_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [A_W-1:0]       rsp_data,
  output logic [CNT_W-1:0]     ops_cnt
);

  state_t            state_q;
  logic [ID_W-1:0]   rrPtr_q;
  logic [A_W-1:0]    opA_q;
  logic [B_W-1:0]    opB_q;
  logic [ID_W-1:0]   rspId_q;
  logic [A_W-1:0]    rspData_q;
  logic              rspValid_q;
  logic [CNT_W-1:0]  opsCnt_q;

  logic              grantHit_d;
  logic [ID_W-1:0]   grantIdx_d;
  logic [ID_W-1:0]   cand;
  logic [A_W-1:0]    selA_d;
  logic [B_W-1:0]    selB_d;
  logic [A_W-1:0]    product_d;

  // Search upward from the round-robin pointer for the first pending request.
  always_comb begin
    grantHit_d = 1'b0;
    grantIdx_d = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'(wrapAdd(int'(rrPtr_q), k, N_REQ));
      if (!grantHit_d && req_valid[cand]) begin
        grantHit_d = 1'b1;
        grantIdx_d = cand;
      end
    end
  end

  // One-hot accept, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && (state_q == ST_IDLE) && grantHit_d) begin
      req_ready[grantIdx_d] = 1'b1;
    end
  end

  // Route the granted requester's operands toward the operand registers.
  always_comb begin
    selA_d = '0;
    selB_d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grantIdx_d == ID_W'(k)) begin
        selA_d = req_a[k*A_W +: A_W];
        selB_d = req_b[k*B_W +: B_W];
      end
    end
  end

  fpga_test_step_mul_32s_8ns_32_1_1 #(
    .NUM_STAGE  (0),
    .din0_WIDTH (A_W),
    .din1_WIDTH (B_W),
    .dout_WIDTH (A_W)
  ) uMul (
    .din0 (opA_q),
    .din1 (opB_q),
    .dout (product_d)
  );

  // Operation sequencer: grant in IDLE, capture product in MUL, hold in RSP.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      rrPtr_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      rspId_q    <= '0;
      rspData_q  <= '0;
      rspValid_q <= 1'b0;
      opsCnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grantHit_d) begin
            opA_q   <= selA_d;
            opB_q   <= selB_d;
            rspId_q <= grantIdx_d;
            rrPtr_q <= ID_W'(wrapInc(int'(grantIdx_d), N_REQ));
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          rspData_q  <= product_d;
          rspValid_q <= 1'b1;
          state_q    <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            opsCnt_q   <= opsCnt_q + 16'd1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          rspValid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspData_q;
  assign ops_cnt   = opsCnt_q;

endmodule

// File: tb/tb_fpga_test_step_mul_arb.sv
// Scoreboard bench for the round-robin multiplier arbiter. The driver grants
// against a transaction-level round-robin model and queues expected results;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_fpga_test_step_mul_arb;

  localparam int N_REQ = 4;
  localparam int A_W   = 32;
  localparam int B_W   = 8;
  localparam int ID_W  = 2;

  logic                 ap_clk    = 1'b0;
  logic                 ap_rst_n  = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a     = '0;
  logic [N_REQ*B_W-1:0] req_b     = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [ID_W-1:0]      rsp_id;
  logic [A_W-1:0]       rsp_data;
  logic [15:0]          ops_cnt;

  always #5 ap_clk = ~ap_clk;

  fpga_test_step_mul_arb #(
    .N_REQ (N_REQ),
    .A_W   (A_W),
    .B_W   (B_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .ops_cnt   (ops_cnt)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          grantCyc;
  } exp_t;

  exp_t        expQ[$];
  int          dutGrants[$];
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  bit          modelFree = 1'b1;
  int          rrPtr     = 0;
  logic [15:0] modelCnt  = '0;

  // Free-running cycle index used to time the expected response.
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Reference product: signed a times unsigned b, keep the low 32 bits.
  function automatic logic [31:0] refProduct(input logic [31:0] a, input logic [7:0] b);
    longint sa;
    longint ub;
    longint p;
    sa = longint'($signed(a));
    ub = longint'(b);
    p  = sa * ub;
    return p[31:0];
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; if the model says the arbiter is free it decides the
  // grant, checks req_ready and queues the expected response.
  task automatic applyStimulus(input logic [3:0] v, input logic [127:0] a, input logic [31:0] b,
                               input bit rr, input bit useLit, input logic [31:0] lit);
    logic [3:0] expReady;
    int         g;
    bit         found;
    exp_t       e;
    @(posedge ap_clk);
    #1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #2;
    expReady = '0;
    found    = 1'b0;
    g        = 0;
    if (modelFree) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && v[(rrPtr + k) % N_REQ]) begin
          found = 1'b1;
          g     = (rrPtr + k) % N_REQ;
        end
      end
    end
    if (found) begin
      expReady[g] = 1'b1;
      e.id        = g;
      e.data      = useLit ? lit : refProduct(a[g*32 +: 32], b[g*8 +: 8]);
      e.grantCyc  = cyc;
      expQ.push_back(e);
      rrPtr     = (g + 1) % N_REQ;
      modelFree = 1'b0;
    end
    checkOutput("req_ready", req_ready, expReady);
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ready[k]) dutGrants.push_back(k);
    end
  endtask

  task automatic idleCycles(input int n, input bit rr);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, '0, '0, rr, 1'b0, '0);
  endtask

  // Synchronous reset for n cycles with every request raised, then check the
  // first post-reset cycle.
  task automatic resetDut(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ap_clk);
      #1;
      ap_rst_n  = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      #2;
      checkOutput("req_ready_in_reset", req_ready, 0);
    end
    expQ.delete();
    modelFree = 1'b1;
    rrPtr     = 0;
    modelCnt  = '0;
    @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_ops_cnt", ops_cnt, 0);
  endtask

  function automatic logic [127:0] onePortA(input int port, input logic [31:0] val);
    logic [127:0] r;
    r = '0;
    r[port*32 +: 32] = val;
    return r;
  endfunction

  function automatic logic [31:0] onePortB(input int port, input logic [7:0] val);
    logic [31:0] r;
    r = '0;
    r[port*8 +: 8] = val;
    return r;
  endfunction

  // Monitor: expect a response two cycles after its grant, compare it while it
  // is presented, and retire it on the handshake.
  initial begin
    bit expV;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        expV = (expQ.size() > 0) && (cyc >= expQ[0].grantCyc + 2);
        checkOutput("rsp_valid", rsp_valid, expV);
        checkOutput("ops_cnt", ops_cnt, modelCnt);
        if (expV) begin
          checkOutput("rsp_id", rsp_id, expQ[0].id);
          checkOutput("rsp_data", rsp_data, expQ[0].data);
          if (rsp_ready) begin
            void'(expQ.pop_front());
            modelCnt  = modelCnt + 16'd1;
            modelFree = 1'b1;
          end
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized stretch.
  initial begin
    int fairExp[5];
    fairExp = '{0, 1, 2, 3, 0};

    resetDut(2);
    idleCycles(2, 1'b1);

    // Single request on port 0: -3 * 200.
    applyStimulus(4'b0001, onePortA(0, 32'hFFFFFFFD), onePortB(0, 8'd200), 1'b1, 1'b1, 32'hFFFFFDA8);
    idleCycles(3, 1'b1);
    checkOutput("ops_cnt_single", ops_cnt, 1);

    // Two's-complement wrap cases.
    applyStimulus(4'b0010, onePortA(1, 32'h7FFFFFFF), onePortB(1, 8'd2), 1'b1, 1'b1, 32'hFFFFFFFE);
    idleCycles(3, 1'b1);
    applyStimulus(4'b1000, onePortA(3, 32'h80000000), onePortB(3, 8'd255), 1'b1, 1'b1, 32'h80000000);
    idleCycles(3, 1'b1);

    // Fairness with every request held high.
    resetDut(1);
    dutGrants.delete();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(4'b1111, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b0, '0);
    end
    checkOutput("fair_grant_count", dutGrants.size(), 5);
    if (dutGrants.size() == 5) begin
      for (int i = 0; i < 5; i++) checkOutput("fair_grant_order", dutGrants[i], fairExp[i]);
    end
    idleCycles(3, 1'b1);

    // Back-pressure: response held for five cycles while others wait.
    applyStimulus(4'b0100, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b0, 1'b0, '0);
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b0, 1'b0, '0);
    end
    applyStimulus(4'b1111, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b0, '0);
    applyStimulus(4'b1111, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b0, '0);
    idleCycles(3, 1'b1);

    // Reset during MUL: operation abandoned, pointer back to zero.
    applyStimulus(4'b0010, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b0, '0);
    resetDut(1);
    applyStimulus(4'b0101, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b0, '0);
    idleCycles(3, 1'b1);
    applyStimulus(4'b0100, onePortA(2, 32'd1234), onePortB(2, 8'd7), 1'b1, 1'b1, 32'd8638);
    idleCycles(3, 1'b1);

    // Randomized traffic with random back-pressure and dropped requests.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom}, $urandom,
                    ($urandom_range(0, 3) != 0), 1'b0, '0);
    end
    idleCycles(4, 1'b1);

    // Counter wrap: preload the count just below wrap, then complete one op.
    @(posedge ap_clk);
    #1;
    force dut.opsCnt_q = 16'hFFFF;
    modelCnt = 16'hFFFF;
    @(posedge ap_clk);
    #1;
    release dut.opsCnt_q;
    applyStimulus(4'b0001, onePortA(0, 32'd5), onePortB(0, 8'd5), 1'b1, 1'b1, 32'd25);
    idleCycles(3, 1'b1);
    checkOutput("ops_cnt_wrap", ops_cnt, 0);
    idleCycles(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
